dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter: MAX_LOCK, default 8, maximum consecutive locked grants to port 1 while port 0 waits.
REQ-002 Clk  in  1  clock; all state updates on posedge Clk.
REQ-003 Rst  in  1  reset, asynchronous, active-low.
REQ-004 p0_req, p0_we  in  1 each  core data port: request; write-enable (1 = write, 0 = read).
REQ-005 p0_addr, p0_wdata  in  32 each  core address and write data.
REQ-006 p0_gnt, p0_rvalid  out  1 each  core grant (same cycle); read data valid.
REQ-007 p0_rdata  out  32  core read data.
REQ-008 p1_req, p1_we, p1_lock  in  1 each  loader/debug port: request; write-enable; burst lock.
REQ-009 p1_addr, p1_wdata  in  32 each  loader address and write data.
REQ-010 p1_gnt, p1_rvalid  out  1 each; p1_rdata  out  32  loader grant, read-valid and read data.
REQ-011 m_addr, m_wdata  out  32 each  address and write data to the single-port data memory.
REQ-012 m_read, m_write  out  1 each  memory read and write strobes.
REQ-013 m_rdata  in  32  memory read data, valid one cycle after m_read.
REQ-014 stall  out  1  holds the core PC while the core's memory access is not granted.

Function
REQ-015 At most one of p0_gnt and p1_gnt SHALL be 1 in any cycle.
REQ-016 Grant SHALL be combinational from the current requests and the registered state; a grant is only asserted to a requesting port.
REQ-017 With a single requester, that port SHALL be granted.
REQ-018 With both requesting and no lock in force, the port not granted last (pointer lp) SHALL win (round-robin).
REQ-019 Lock in force: p1 granted last cycle, p1_req=1, p1_lock=1, and lock counter lcnt < MAX_LOCK; p1 SHALL win regardless of lp.
REQ-020 lcnt SHALL increment on each p1 grant made while p0_req=1 and p1_lock=1.
REQ-021 lcnt SHALL clear on any p0 grant, and on any cycle in which p1_lock=0 or p1_req=0.
REQ-022 When lcnt = MAX_LOCK and p0_req=1, p0 SHALL be granted for one cycle; then lcnt clears and the lock may resume.
REQ-023 lp SHALL update on every cycle with a grant, to the granted port index, and SHALL hold otherwise.
REQ-024 m_addr and m_wdata SHALL be the granted port's address and data.
REQ-025 m_read SHALL equal the granted port's ~we; m_write SHALL equal its we.
REQ-026 With no grant: m_read=0, m_write=0, m_addr=0, m_wdata=0.
REQ-027 Granted read in cycle N: registered px_rvalid=1 in cycle N+1 only; px_rdata=m_rdata in that cycle.
REQ-028 px_rdata SHALL be 0 whenever px_rvalid=0.
REQ-029 Writes SHALL complete in the grant cycle and produce no rvalid.
REQ-030 stall SHALL equal p0_req & ~p0_gnt (combinational).
REQ-031 Back-to-back grants SHALL be sustainable every cycle, with no bubble between reads, writes or ports.
REQ-032 Requests dropped before grant SHALL leave no side effects; a port is not required to hold req.

Reset
REQ-033 While Rst=0: lp=1 (p0 wins the first tie), lcnt=0, p0_rvalid=p1_rvalid=0, all px_rdata=0.
REQ-034 While Rst=0: all grants, m_read, m_write and stall SHALL be 0, and m_addr and m_wdata SHALL be 0.
REQ-035 Reset asserted mid-read SHALL cancel the pending rvalid; no rvalid SHALL appear after Rst deasserts.

Verification
REQ-036 Solo core: p0 read addr 0x10, m_rdata=0xDEADBEEF next cycle -> p0_gnt=1, m_read=1, m_addr=0x10; next cycle p0_rvalid=1, p0_rdata=0xDEADBEEF, stall=0 throughout.
REQ-037 Tie after reset: both request every cycle, no lock -> grants alternate p0,p1,p0,p1; stall=1 on p1 cycles; never two grants in one cycle.
REQ-038 Lock, MAX_LOCK=8: p1_lock=1 and both requesting continuously -> 8 p1 grants, 1 p0 grant, 8 p1 grants, repeating.
REQ-039 Lock released after 3 locked grants -> next tie goes to p0 via lp; lcnt=0.
REQ-040 Mixed traffic: p1 write 0x55 to 0x20 then p0 read 0x20 -> m_write=1 with m_wdata=0x55 then m_read=1; p1_rvalid stays 0; p0_rvalid=1 one cycle later.
REQ-041 Rst pulsed low in the cycle after a p0 read grant -> p0_rvalid=0 and all outputs 0 during reset; no rvalid after release; first tie goes to p0.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: core/loader arbiter in front of one single-port data memory.
// Round-robin on ties, with a bounded burst lock for the loader port.
module dmem_arbiter #(
  parameter int MAX_LOCK = 8
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_wdata,
  output logic        p0_gnt,
  output logic        p0_rvalid,
  output logic [31:0] p0_rdata,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic        p1_lock,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_wdata,
  output logic        p1_gnt,
  output logic        p1_rvalid,
  output logic [31:0] p1_rdata,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic        m_read,
  output logic        m_write,
  input  logic [31:0] m_rdata,
  output logic        stall
);

  localparam int LW = $clog2(MAX_LOCK + 1);
  localparam logic [LW-1:0] LMAX = LW'(MAX_LOCK);

  logic          lp_q, lp_d;
  logic          p1_last_q, p1_last_d;
  logic [LW-1:0] lcnt_q, lcnt_d;
  logic          p0_rv_q, p0_rv_d;
  logic          p1_rv_q, p1_rv_d;
  logic          lock_on, starve;
  logic          g0, g1;

  always_comb begin
    lock_on = p1_last_q & p1_req & p1_lock
            & (lcnt_q < LMAX);
    starve  = p0_req & (lcnt_q == LMAX);
    g0 = 1'b0;
    g1 = 1'b0;
    // Nothing is granted while reset is held.
    if (Rst) begin
      if (p0_req & p1_req) begin
        if (starve)       g0 = 1'b1;
        else if (lock_on) g1 = 1'b1;
        else if (lp_q)    g0 = 1'b1;
        else              g1 = 1'b1;
      end else begin
        g0 = p0_req;
        g1 = p1_req;
      end
    end
  end

  always_comb begin
    m_addr  = '0;
    m_wdata = '0;
    m_read  = 1'b0;
    m_write = 1'b0;
    unique case (1'b1)
      g0: begin
        m_addr  = p0_addr;
        m_wdata = p0_wdata;
        m_read  = ~p0_we;
        m_write = p0_we;
      end
      g1: begin
        m_addr  = p1_addr;
        m_wdata = p1_wdata;
        m_read  = ~p1_we;
        m_write = p1_we;
      end
      default: ;
    endcase
  end

  always_comb begin
    lp_d = lp_q;
    if (g0)      lp_d = 1'b0;
    else if (g1) lp_d = 1'b1;
    p1_last_d = g1;
    lcnt_d = lcnt_q;
    if (g0 | ~p1_lock | ~p1_req)
      lcnt_d = '0;
    else if (g1 & p0_req & (lcnt_q < LMAX))
      lcnt_d = lcnt_q + LW'(1);
    p0_rv_d = g0 & ~p0_we;
    p1_rv_d = g1 & ~p1_we;
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      lp_q      <= 1'b1;
      p1_last_q <= 1'b0;
      lcnt_q    <= '0;
      p0_rv_q   <= 1'b0;
      p1_rv_q   <= 1'b0;
    end else begin
      lp_q      <= lp_d;
      p1_last_q <= p1_last_d;
      lcnt_q    <= lcnt_d;
      p0_rv_q   <= p0_rv_d;
      p1_rv_q   <= p1_rv_d;
    end
  end

  assign p0_gnt    = g0;
  assign p1_gnt    = g1;
  assign p0_rvalid = p0_rv_q;
  assign p1_rvalid = p1_rv_q;
  assign p0_rdata  = p0_rv_q ? m_rdata : '0;
  assign p1_rdata  = p1_rv_q ? m_rdata : '0;
  assign stall     = Rst & p0_req & ~g0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: scoreboard bench for dmem_arbiter.
// Read expectations are queued at grant and retired on rvalid.
module tb_dmem_arbiter;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        p0_req, p0_we, p1_req, p1_we, p1_lock;
  logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic        p0_gnt, p0_rvalid, p1_gnt, p1_rvalid;
  logic [31:0] p0_rdata, p1_rdata;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic        m_read, m_write, stall;

  typedef struct packed {
    logic        port;
    logic [31:0] data;
  } rd_t;

  rd_t sb[$];
  int  n_tests = 0;
  int  n_fail  = 0;

  logic [31:0]   wmem [0:4095];
  logic [4095:0] wset = '0;

  always #5 Clk = ~Clk;

  dmem_arbiter #(.MAX_LOCK(8)) dut (
    .Clk(Clk), .Rst(Rst),
    .p0_req(p0_req), .p0_we(p0_we),
    .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid),
    .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we),
    .p1_lock(p1_lock),
    .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid),
    .p1_rdata(p1_rdata),
    .m_addr(m_addr), .m_wdata(m_wdata),
    .m_read(m_read), .m_write(m_write),
    .m_rdata(m_rdata), .stall(stall)
  );

  function automatic logic [31:0] mem_fn(
    input logic [31:0] a);
    return (a == 32'h10) ? 32'hDEADBEEF
                         : {a[15:0], ~a[15:0]};
  endfunction

  // Memory model: one-cycle read latency, garbage when idle.
  always @(posedge Clk) begin
    if (m_write) begin
      wmem[m_addr[11:0]] <= m_wdata;
      wset[m_addr[11:0]] <= 1'b1;
    end
    if (m_read)
      m_rdata <= wset[m_addr[11:0]] ? wmem[m_addr[11:0]]
                                    : mem_fn(m_addr);
    else
      m_rdata <= 32'hBAD0BAD0;
  end

  always @(negedge Clk) begin
    if (p0_rvalid || p1_rvalid) begin
      n_tests++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL rv_spurious: rv0=%b rv1=%b want none",
                 p0_rvalid, p1_rvalid);
      end else begin
        rd_t e;
        logic [31:0] got;
        e = sb.pop_front();
        got = e.port ? p1_rdata : p0_rdata;
        if ({p0_rvalid, p1_rvalid} !== {~e.port, e.port}
            || got !== e.data) begin
          n_fail++;
          $display("FAIL rv_data: rv=%b%b data=%h want p%0d %h",
                   p0_rvalid, p1_rvalid, got, e.port, e.data);
        end
      end
    end
    n_tests++;
    if ((!p0_rvalid && p0_rdata !== 32'h0)
        || (!p1_rvalid && p1_rdata !== 32'h0)) begin
      n_fail++;
      $display("FAIL rdata_idle: p0=%h p1=%h want 0",
               p0_rdata, p1_rdata);
    end
  end

  task automatic clear_in;
    p0_req = 0; p0_we = 0; p0_addr = 0; p0_wdata = 0;
    p1_req = 0; p1_we = 0; p1_lock = 0;
    p1_addr = 0; p1_wdata = 0;
  endtask

  task automatic do_reset;
    clear_in();
    Rst = 0;
    @(posedge Clk); #1;
    Rst = 1;
  endtask

  task automatic test_reset;
    Rst = 0;
    p0_req = 1; p1_req = 1; p1_lock = 1; p1_we = 1;
    p0_addr = 32'h10; p1_addr = 32'h44;
    p1_wdata = 32'h77; p0_wdata = 32'h99;
    @(negedge Clk);
    n_tests++;
    if ({p0_gnt, p1_gnt, stall} !== 3'b000) begin
      n_fail++;
      $display("FAIL rst_gnt: gnt=%b%b stall=%b want 000",
               p0_gnt, p1_gnt, stall);
    end
    n_tests++;
    if ({m_read, m_write} !== 2'b00) begin
      n_fail++;
      $display("FAIL rst_strobe: rd=%b wr=%b want 0",
               m_read, m_write);
    end
    n_tests++;
    if (m_addr !== 32'h0 || m_wdata !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_bus: addr=%h wdata=%h want 0",
               m_addr, m_wdata);
    end
    n_tests++;
    if ({p0_rvalid, p1_rvalid} !== 2'b00) begin
      n_fail++;
      $display("FAIL rst_rv: rv=%b%b want 00",
               p0_rvalid, p1_rvalid);
    end
    @(posedge Clk); #1;
    clear_in();
    Rst = 1;
  endtask

  task automatic test_solo;
    p0_req = 1; p0_we = 0; p0_addr = 32'h10;
    @(negedge Clk);
    n_tests++;
    if ({p0_gnt, p1_gnt, m_read, m_write, stall}
        !== 5'b10100 || m_addr !== 32'h10) begin
      n_fail++;
      $display("FAIL solo_gnt: g=%b%b rd=%b wr=%b st=%b a=%h want 10100 a=10",
               p0_gnt, p1_gnt, m_read, m_write, stall, m_addr);
    end
    sb.push_back({1'b0, 32'hDEADBEEF});
    @(posedge Clk); #1;
    p0_req = 0;
    @(negedge Clk);
    n_tests++;
    if (stall !== 1'b0) begin
      n_fail++;
      $display("FAIL solo_stall: stall=%b want 0", stall);
    end
    @(posedge Clk); #1;
  endtask

  task automatic test_tie;
    do_reset();
    p0_req = 1; p1_req = 1;
    for (int i = 0; i < 8; i++) begin
      logic        w;
      logic [31:0] a;
      p0_addr = 32'h100 + i;
      p1_addr = 32'h200 + i;
      w = i[0];
      a = w ? p1_addr : p0_addr;
      @(negedge Clk);
      n_tests++;
      if ({p0_gnt, p1_gnt} !== {~w, w} || stall !== w
          || m_read !== 1'b1 || m_addr !== a) begin
        n_fail++;
        $display("FAIL tie_%0d: g=%b%b st=%b rd=%b a=%h want g=%b%b a=%h",
                 i, p0_gnt, p1_gnt, stall, m_read, m_addr,
                 ~w, w, a);
      end
      sb.push_back({w, mem_fn(a)});
      @(posedge Clk); #1;
    end
    clear_in();
    @(negedge Clk);
    @(posedge Clk); #1;
  endtask

  task automatic test_lock;
    do_reset();
    p0_req = 1; p1_req = 1; p1_lock = 1;
    p0_we = 0; p1_we = 1;
    for (int c = 0; c < 27; c++) begin
      logic        w;
      logic [31:0] a;
      p0_addr = 32'h300 + c;
      p1_addr = 32'h400 + c;
      p1_wdata = 32'hC0DE_0000 + c;
      w = (c % 9) != 0;
      a = w ? p1_addr : p0_addr;
      @(negedge Clk);
      n_tests++;
      if ({p0_gnt, p1_gnt} !== {~w, w}
          || {m_read, m_write} !== {~w, w}
          || m_addr !== a) begin
        n_fail++;
        $display("FAIL lock_%0d: g=%b%b rd=%b wr=%b a=%h want g=%b%b a=%h",
                 c, p0_gnt, p1_gnt, m_read, m_write, m_addr,
                 ~w, w, a);
      end
      if (!w) sb.push_back({1'b0, mem_fn(a)});
      @(posedge Clk); #1;
    end
    clear_in();
    @(negedge Clk);
    @(posedge Clk); #1;
  endtask

  task automatic test_lock_release;
    do_reset();
    p0_we = 1; p1_we = 1; p1_req = 1;
    for (int c = 0; c < 18; c++) begin
      logic w;
      p0_req  = (c != 4);
      p1_lock = (c != 4) && (c != 17);
      p0_addr = 32'h600 + c;
      p1_addr = 32'h700 + c;
      w = !(c == 0 || c == 13 || c == 17);
      @(negedge Clk);
      n_tests++;
      if ({p0_gnt, p1_gnt} !== {~w, w}
          || stall !== (p0_req & w)) begin
        n_fail++;
        $display("FAIL rel_%0d: g=%b%b st=%b want g=%b%b st=%b",
                 c, p0_gnt, p1_gnt, stall, ~w, w, p0_req & w);
      end
      @(posedge Clk); #1;
    end
    clear_in();
    @(negedge Clk);
    @(posedge Clk); #1;
  endtask

  task automatic test_mixed;
    do_reset();
    p1_req = 1; p1_we = 1;
    p1_addr = 32'h20; p1_wdata = 32'h55;
    @(negedge Clk);
    n_tests++;
    if ({p1_gnt, m_write, m_read} !== 3'b110
        || m_wdata !== 32'h55 || m_addr !== 32'h20) begin
      n_fail++;
      $display("FAIL mix_wr: g1=%b wr=%b rd=%b a=%h d=%h want 110 20 55",
               p1_gnt, m_write, m_read, m_addr, m_wdata);
    end
    @(posedge Clk); #1;
    clear_in();
    p0_req = 1; p0_we = 0; p0_addr = 32'h20;
    @(negedge Clk);
    n_tests++;
    if ({p0_gnt, m_read, m_write} !== 3'b110
        || m_addr !== 32'h20) begin
      n_fail++;
      $display("FAIL mix_rd: g0=%b rd=%b wr=%b a=%h want 110 20",
               p0_gnt, m_read, m_write, m_addr);
    end
    sb.push_back({1'b0, 32'h55});
    @(posedge Clk); #1;
    clear_in();
    @(negedge Clk);
    @(posedge Clk); #1;
  endtask

  task automatic test_reset_mid_read;
    do_reset();
    p0_req = 1; p0_we = 0; p0_addr = 32'h10;
    @(negedge Clk);
    n_tests++;
    if (p0_gnt !== 1'b1) begin
      n_fail++;
      $display("FAIL mrst_gnt: g0=%b want 1", p0_gnt);
    end
    @(posedge Clk); #1;
    Rst = 0;
    p1_req = 1; p1_addr = 32'h24;
    @(negedge Clk);
    n_tests++;
    if ({p0_rvalid, p0_gnt, p1_gnt, stall, m_read}
        !== 5'b0 || p0_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL mrst_out: rv=%b g=%b%b st=%b rd=%b d=%h want 0",
               p0_rvalid, p0_gnt, p1_gnt, stall, m_read,
               p0_rdata);
    end
    @(posedge Clk); #1;
    Rst = 1;
    @(negedge Clk);
    n_tests++;
    if ({p0_gnt, p1_gnt} !== 2'b10) begin
      n_fail++;
      $display("FAIL mrst_tie: g=%b%b want 10", p0_gnt, p1_gnt);
    end
    sb.push_back({1'b0, 32'hDEADBEEF});
    @(posedge Clk); #1;
    clear_in();
    @(negedge Clk);
    @(posedge Clk); #1;
  endtask

  initial begin
    clear_in();
    #2 Rst = 0;
    repeat (2) @(posedge Clk);
    #1;
    test_reset();
    test_solo();
    test_tie();
    test_lock();
    test_lock_release();
    test_mixed();
    test_reset_mid_read();
    repeat (2) @(posedge Clk);
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: %0d pending want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
